// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_pkg
// Purpose  : Op codes and request record shared by the ALU-sharing arbiter.
// Revision : 1.0
// ============================================================================
package alu_share_arbiter_pkg;

  typedef logic [4:0] op_t;

  localparam op_t OP_ADD  = 5'd0;
  localparam op_t OP_SUB  = 5'd1;
  localparam op_t OP_AND  = 5'd2;
  localparam op_t OP_OR   = 5'd3;
  localparam op_t OP_XOR  = 5'd4;
  localparam op_t OP_NOR  = 5'd5;
  localparam op_t OP_SLL  = 5'd6;
  localparam op_t OP_SRL  = 5'd7;
  localparam op_t OP_SRA  = 5'd8;
  localparam op_t OP_SLT  = 5'd9;
  localparam op_t OP_LAST = OP_SLT;

  typedef struct packed {
    op_t         conf;
    logic        sign;
    logic [31:0] in1;
    logic [31:0] in2;
  } req_t;

  function automatic logic op_supported(op_t op);
    return op <= OP_LAST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Two-port request/response bundle between requesters and arbiter.
// Revision : 1.0
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int CNT_W = 16
);
  import alu_share_arbiter_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  op_t              req0_conf;
  logic             req0_sign;
  logic [31:0]      req0_in1;
  logic [31:0]      req0_in2;
  logic             req1_valid;
  logic             req1_ready;
  op_t              req1_conf;
  logic             req1_sign;
  logic [31:0]      req1_in1;
  logic [31:0]      req1_in2;
  logic             resp0_valid;
  logic [31:0]      resp0_result;
  logic             resp0_err;
  logic             resp1_valid;
  logic [31:0]      resp1_result;
  logic             resp1_err;
  logic [CNT_W-1:0] grant0_cnt;
  logic [CNT_W-1:0] grant1_cnt;

  modport master (
    output req0_valid, req0_conf, req0_sign, req0_in1, req0_in2,
    output req1_valid, req1_conf, req1_sign, req1_in1, req1_in2,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_result, resp0_err,
    input  resp1_valid, resp1_result, resp1_err,
    input  grant0_cnt, grant1_cnt
  );

  modport slave (
    input  req0_valid, req0_conf, req0_sign, req0_in1, req0_in2,
    input  req1_valid, req1_conf, req1_sign, req1_in1, req1_in2,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_result, resp0_err,
    output resp1_valid, resp1_result, resp1_err,
    output grant0_cnt, grant1_cnt
  );

endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Purely combinational 32-bit ALU with unsupported-op flag.
// Revision : 1.0
// ============================================================================
module alu_core
  import alu_share_arbiter_pkg::*;
(
  input  req_t        req_i,
  output logic [31:0] result_o,
  output logic        err_o
);

  logic       w_big_shift;
  logic [4:0] w_shamt;
  logic       w_lt;

  // Any set bit above bit 4 means the amount is 32 or more.
  assign w_big_shift = |req_i.in1[31:5];
  assign w_shamt     = req_i.in1[4:0];
  assign w_lt        = req_i.sign ? ($signed(req_i.in1) < $signed(req_i.in2))
                                  : (req_i.in1 < req_i.in2);

  always_comb begin
    result_o = 32'h0;
    err_o    = !op_supported(req_i.conf);
    case (req_i.conf)
      OP_ADD: result_o = req_i.in1 + req_i.in2;
      OP_SUB: result_o = req_i.in1 - req_i.in2;
      OP_AND: result_o = req_i.in1 & req_i.in2;
      OP_OR:  result_o = req_i.in1 | req_i.in2;
      OP_XOR: result_o = req_i.in1 ^ req_i.in2;
      OP_NOR: result_o = ~(req_i.in1 | req_i.in2);
      OP_SLL: result_o = w_big_shift ? 32'h0 : (req_i.in2 << w_shamt);
      OP_SRL: result_o = w_big_shift ? 32'h0 : (req_i.in2 >> w_shamt);
      OP_SRA: result_o = w_big_shift ? {32{req_i.in2[31]}}
                                     : $unsigned($signed(req_i.in2) >>> w_shamt);
      OP_SLT: result_o = {31'h0, w_lt};
      default: result_o = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one ALU between two requesters, registered 1-cycle reply.
// Revision : 1.0
// ============================================================================
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  alu_share_arbiter_if.slave bus
);

  logic [1:0]  valid;
  req_t        req [2];
  logic [1:0]  grant;
  logic        last_grant_q;
  logic        last_grant_d;
  req_t        alu_req;
  logic [31:0] alu_result;
  logic        alu_err;

  assign valid[0] = bus.req0_valid;
  assign valid[1] = bus.req1_valid;
  assign req[0]   = '{conf: bus.req0_conf, sign: bus.req0_sign,
                      in1: bus.req0_in1, in2: bus.req0_in2};
  assign req[1]   = '{conf: bus.req1_conf, sign: bus.req1_sign,
                      in1: bus.req1_in1, in2: bus.req1_in2};

  // last_grant_q==1 means port 1 won last, so port 0 takes the next tie.
  always_comb begin
    grant = 2'b00;
    if (reset) begin
      if (valid[0] && (!valid[1] || FIXED_PRIO || last_grant_q)) begin
        grant[0] = 1'b1;
      end else if (valid[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  assign last_grant_d = (|grant) ? grant[1] : last_grant_q;
  assign alu_req      = grant[1] ? req[1] : req[0];

  alu_core u_alu (
    .req_i    (alu_req),
    .result_o (alu_result),
    .err_o    (alu_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic             resp_valid_q;
    logic [31:0]      resp_result_q;
    logic             resp_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
      if (!reset) begin
        resp_valid_q  <= 1'b0;
        resp_result_q <= 32'h0;
        resp_err_q    <= 1'b0;
        cnt_q         <= '0;
      end else begin
        resp_valid_q <= grant[p];
        if (grant[p]) begin
          resp_result_q <= alu_result;
          resp_err_q    <= alu_err;
          cnt_q         <= cnt_d;
        end
      end
    end
  end

  assign bus.req0_ready   = grant[0];
  assign bus.req1_ready   = grant[1];
  assign bus.resp0_valid  = g_port[0].resp_valid_q;
  assign bus.resp0_result = g_port[0].resp_result_q;
  assign bus.resp0_err    = g_port[0].resp_err_q;
  assign bus.resp1_valid  = g_port[1].resp_valid_q;
  assign bus.resp1_result = g_port[1].resp_result_q;
  assign bus.resp1_err    = g_port[1].resp_err_q;
  assign bus.grant0_cnt   = g_port[0].cnt_q;
  assign bus.grant1_cnt   = g_port[1].cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Round-robin and fixed-priority arbiters against a reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  typedef struct {
    int          port;
    logic [4:0]  conf;
    logic        sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic reset;

  // Index [d][p]: d=0 round-robin instance, d=1 fixed-priority instance.
  logic [1:0][1:0]        drv_v;
  req_t                   drv_r [2][2];
  logic [1:0][1:0]        mon_rdy;
  logic [1:0][1:0]        mon_rv;
  logic [1:0][1:0][31:0]  mon_res;
  logic [1:0][1:0]        mon_err;
  logic [1:0][1:0][15:0]  mon_cnt;

  int          m_last [2];
  logic        m_g    [2][2];
  logic        m_rv   [2][2];
  logic [31:0] m_res  [2][2];
  logic        m_err  [2][2];
  logic [15:0] m_cnt  [2][2];
  logic        s_rdy  [2][2];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    alu_share_arbiter_if #(.CNT_W(16)) bus ();

    alu_share_arbiter #(.FIXED_PRIO(1'(d)), .CNT_W(16)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.req0_valid = drv_v[d][0];
    assign bus.req0_conf  = drv_r[d][0].conf;
    assign bus.req0_sign  = drv_r[d][0].sign;
    assign bus.req0_in1   = drv_r[d][0].in1;
    assign bus.req0_in2   = drv_r[d][0].in2;
    assign bus.req1_valid = drv_v[d][1];
    assign bus.req1_conf  = drv_r[d][1].conf;
    assign bus.req1_sign  = drv_r[d][1].sign;
    assign bus.req1_in1   = drv_r[d][1].in1;
    assign bus.req1_in2   = drv_r[d][1].in2;
    assign mon_rdy[d] = {bus.req1_ready, bus.req0_ready};
    assign mon_rv[d]  = {bus.resp1_valid, bus.resp0_valid};
    assign mon_res[d] = {bus.resp1_result, bus.resp0_result};
    assign mon_err[d] = {bus.resp1_err, bus.resp0_err};
    assign mon_cnt[d] = {bus.grant1_cnt, bus.grant0_cnt};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU built from repeated doubling/halving and biased compares.
  function automatic void ref_alu(input req_t r, output logic [31:0] res, output logic err);
    logic [31:0] a;
    logic [31:0] b;
    int unsigned n;
    a   = r.in1;
    b   = r.in2;
    res = 32'h0;
    err = 1'b0;
    n   = (a >= 32) ? 32 : a;
    case (int'(r.conf))
      0: res = a + b;
      1: res = a - b;
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = ~(a | b);
      6: begin res = b; repeat (n) res = res * 2; end
      7: begin res = b; repeat (n) res = res / 2; end
      8: begin res = b; repeat (n) res = {res[31], res[31:1]}; end
      9: res = r.sign ? 32'((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) : 32'(a < b);
      default: err = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1;
      for (int p = 0; p < 2; p++) begin
        m_g[d][p] = 1'b0; m_rv[d][p] = 1'b0; m_res[d][p] = 32'h0;
        m_err[d][p] = 1'b0; m_cnt[d][p] = 16'h0;
      end
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step();
    logic e [2];
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("resp_valid d%0d p%0d", d, p), 32'(mon_rv[d][p]), 32'(m_rv[d][p]));
        chk($sformatf("resp_result d%0d p%0d", d, p), mon_res[d][p], m_res[d][p]);
        chk($sformatf("resp_err d%0d p%0d", d, p), 32'(mon_err[d][p]), 32'(m_err[d][p]));
        chk($sformatf("grant_cnt d%0d p%0d", d, p), 32'(mon_cnt[d][p]), 32'(m_cnt[d][p]));
      end
      chk($sformatf("resp_excl d%0d", d), 32'(mon_rv[d][0] & mon_rv[d][1]), 32'h0);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      e[0] = 1'b0;
      e[1] = 1'b0;
      if (reset) begin
        if (drv_v[d][0] && drv_v[d][1]) begin
          if (d == 1) e[0] = 1'b1;
          else        e[1 - m_last[d]] = 1'b1;
        end else begin
          e[0] = drv_v[d][0];
          e[1] = drv_v[d][1];
        end
      end
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("ready d%0d p%0d", d, p), 32'(mon_rdy[d][p]), 32'(e[p]));
        s_rdy[d][p] = mon_rdy[d][p];
        m_g[d][p]   = e[p];
      end
      if (reset) begin
        for (int p = 0; p < 2; p++) begin
          m_rv[d][p] = e[p];
          if (e[p]) begin
            ref_alu(drv_r[d][p], m_res[d][p], m_err[d][p]);
            if (m_cnt[d][p] != 16'hFFFF) m_cnt[d][p] = m_cnt[d][p] + 16'h1;
            m_last[d] = p;
          end
        end
      end
    end
    if (!reset) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_both(input int p, input logic v, input req_t r);
    for (int d = 0; d < 2; d++) begin
      drv_v[d][p] = v;
      drv_r[d][p] = r;
    end
  endtask

  task automatic idle_all();
    drv_v = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.conf = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
    r.sign = 1'($urandom_range(0, 1));
    r.in1  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
    r.in2  = $urandom;
    return r;
  endfunction

  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    tbl[0]  = '{0, OP_ADD, 1'b0, 32'd5,          32'd7,          32'd12,         1'b0};
    tbl[1]  = '{1, OP_SLT, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    tbl[2]  = '{1, OP_SLT, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[3]  = '{1, 5'd12,  1'b0, 32'd9,          32'd9,          32'd0,          1'b1};
    tbl[4]  = '{0, OP_SLL, 1'b0, 32'd33,         32'd1,          32'd0,          1'b0};
    tbl[5]  = '{0, OP_SRL, 1'b0, 32'd1,          32'h8000_0000,  32'h4000_0000,  1'b0};
    tbl[6]  = '{1, OP_SRA, 1'b1, 32'd4,          32'h8000_0000,  32'hF800_0000,  1'b0};
    tbl[7]  = '{0, OP_SUB, 1'b1, 32'd10,         32'd3,          32'd7,          1'b0};
    tbl[8]  = '{1, OP_SUB, 1'b0, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
    tbl[9]  = '{0, OP_ADD, 1'b0, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0};
    tbl[10] = '{1, OP_AND, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0};
    tbl[11] = '{0, OP_OR,  1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0,  1'b0};
    tbl[12] = '{1, OP_XOR, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0};
    tbl[13] = '{0, OP_NOR, 1'b0, 32'h0000_00F0,  32'h0000_000F,  32'hFFFF_FF00,  1'b0};
    tbl[14] = '{1, OP_SRA, 1'b0, 32'd40,         32'h8000_0001,  32'hFFFF_FFFF,  1'b0};
    tbl[15] = '{0, OP_SRL, 1'b0, 32'd32,         32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[16] = '{1, OP_SLL, 1'b0, 32'd4,          32'h0000_000F,  32'h0000_00F0,  1'b0};
    tbl[17] = '{0, 5'd31,  1'b1, 32'd1,          32'd1,          32'd0,          1'b1};

    reset = 1'b0;
    drv_v = '0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) drv_r[d][p] = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Single-port table vectors, one result per accept.
    for (int i = 0; i < 18; i++) begin
      drive_both(tbl[i].port, 1'b1, '{tbl[i].conf, tbl[i].sign, tbl[i].in1, tbl[i].in2});
      step();
      chk($sformatf("tbl%0d same-cycle ready", i), 32'(s_rdy[0][tbl[i].port]), 32'h1);
      idle_all();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("tbl%0d d%0d result", i, d), mon_res[d][tbl[i].port], tbl[i].exp_res);
        chk($sformatf("tbl%0d d%0d err", i, d), 32'(mon_err[d][tbl[i].port]), 32'(tbl[i].exp_err));
        chk($sformatf("tbl%0d d%0d valid", i, d), 32'(mon_rv[d][tbl[i].port]), 32'h1);
      end
      if (i == 0) chk("first grant0_cnt", 32'(mon_cnt[0][0]), 32'h1);
      step();
    end

    // Continuous contention: RR alternates, fixed priority starves port 1.
    do_reset();
    drive_both(0, 1'b1, '{OP_SUB, 1'b0, 32'd10, 32'd3});
    drive_both(1, 1'b1, '{OP_SRA, 1'b1, 32'd4, 32'h8000_0000});
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr grant p1 cycle%0d", i), 32'(s_rdy[0][1]), 32'(i % 2));
      chk($sformatf("fp grant p1 cycle%0d", i), 32'(s_rdy[1][1]), 32'h0);
      if (i > 0) begin
        chk($sformatf("rr result cycle%0d", i), mon_res[0][(i - 1) % 2],
            ((i - 1) % 2 == 0) ? 32'd7 : 32'hF800_0000);
        chk($sformatf("fp resp0 pulse cycle%0d", i), 32'(mon_rv[1][0]), 32'h1);
      end
    end
    idle_all();
    step();
    chk("fp grant1_cnt", 32'(mon_cnt[1][1]), 32'h0);
    chk("fp grant0_cnt", 32'(mon_cnt[1][0]), 32'h4);

    // Accept, then reset in the following cycle: the reply is discarded.
    drive_both(0, 1'b1, '{OP_ADD, 1'b0, 32'd1, 32'd1});
    step();
    idle_all();
    reset = 1'b0;
    step();
    drive_both(0, 1'b1, '{OP_ADD, 1'b0, 32'd2, 32'd2});
    drive_both(1, 1'b1, '{OP_ADD, 1'b0, 32'd3, 32'd3});
    step();
    chk("reset resp0_valid", 32'(mon_rv[0][0]), 32'h0);
    chk("reset grant0_cnt", 32'(mon_cnt[0][0]), 32'h0);
    chk("reset ready0", 32'(s_rdy[0][0]), 32'h0);
    reset = 1'b1;
    step();
    chk("post-reset tie p0", 32'(s_rdy[0][0]), 32'h1);
    chk("post-reset tie p1", 32'(s_rdy[0][1]), 32'h0);
    idle_all();
    step();

    // Random traffic; requesters hold until accepted.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (!(drv_v[d][p] && !m_g[d][p])) begin
            drv_v[d][p] = ($urandom_range(0, 9) < 7);
            drv_r[d][p] = rand_req();
          end
        end
      end
      step();
    end
    reset = 1'b1;
    idle_all();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
